stream_serializer: RTL and testbench
====================================

Name: stream_serializer

Overview:
- Takes one WIDTH-bit word per valid/ready handshake and emits it as a sequence of SLICE-bit beats, one beat per accepted output handshake.
- Beat order follows SystemVerilog streaming-operator semantics. Right stream ({>> SLICE {w}}) emits the MSB slice first. Left stream ({<< SLICE {w}}) reverses the slice order.
- It is the time-domain counterpart of the combinational stream pack/unpack paths. It sits between a word-wide producer and a narrow lane.

Parameters:
- WIDTH, 32, input word width in bits (>=1).
- SLICE, 8, beat width in bits (>=1). SLICE > WIDTH is legal and gives one beat.
- NB (localparam), ceil(WIDTH/SLICE), number of beats per word.
- REM (localparam), WIDTH % SLICE, valid bits in the final beat when nonzero.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  word offered.
- in_ready  out  1  word accepted when in_valid & in_ready.
- in_data  in  WIDTH  word.
- in_dir  in  1  0 = right stream (>>), 1 = left stream (<<); sampled with the word.
- out_valid  out  1  beat present.
- out_ready  in  1  beat consumed when out_valid & out_ready.
- out_data  out  SLICE  beat; valid bits are left-justified, padding bits are 0.
- out_nbits  out  $clog2(SLICE+1)  count of valid bits in out_data.
- out_last  out  1  final beat of the current word.

Behaviour:
- Reset state (synchronous on rst=1 at posedge): state=IDLE, beat counter=0, shift register=0, out_valid=0, out_last=0, out_data=0, out_nbits=0. in_ready is 1 in the cycle after reset deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0. An input handshake loads the word and moves to SEND.
  - SEND: out_valid=1. An output handshake on a non-last beat shifts the register and increments the counter. An output handshake on the last beat returns to IDLE, unless a new word is accepted in the same cycle (see back-to-back).
- Load: sreg is NB*SLICE bits and is loaded left-justified with the low pad bits zeroed.
  - in_dir=0: load in_data.
  - in_dir=1: load {<< SLICE {in_data}}. The slice reversal starts at the LSB, so the remainder block (the original top REM bits) lands in the LSBs of the reversed word.
- Emit: out_data = sreg[NB*SLICE-1 -: SLICE]. Each output handshake shifts sreg left by SLICE.
- out_nbits = SLICE on every beat, except the last beat when REM != 0, where out_nbits = REM. out_last = (counter == NB-1).
- Latency: the first beat is visible the cycle after input acceptance. With out_ready held at 1, a word takes exactly NB cycles in SEND.
- Back-to-back: in_ready = IDLE | (SEND & out_valid & out_ready & out_last). A word accepted on the last-beat handshake is loaded in the same cycle, giving zero bubble between words.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_nbits and out_last are held stable. in_valid and in_data are ignored while in_ready=0.
- in_dir is captured into a register at load. Changes on in_dir mid-word have no effect.
- Reset mid-word: the partial word is discarded and no further beats are emitted. The next word starts from beat 0.
- NB=1 (SLICE >= WIDTH): a single beat with out_last=1 and out_nbits=WIDTH; both directions give an identical result.

Decomposition:
- stream_pkg holds:
  - typedef enum logic {STREAM_RIGHT=1'b0, STREAM_LEFT=1'b1} stream_dir_e;
  - typedef enum logic {S_IDLE, S_SEND} stream_ser_state_e;
  - function stream_nbeats(width, slice), returning ceil(width/slice).
- Sub-module stream_slice_reverse #(WIDTH, SLICE): purely combinational {<< SLICE {}}. It is reused by a future stream_deserializer.

Test Plan:
- WIDTH=8, SLICE=2, in_dir=0, in_data=8'hB4, out_ready=1 -> beats 2'b10, 2'b11, 2'b01, 2'b00; out_last on beat 4 only; out_nbits=2 on every beat.
- Same word with in_dir=1 -> beats 2'b00, 2'b01, 2'b11, 2'b10.
- WIDTH=4, SLICE=3:
  - in_dir=1, in_data=4'b1001 -> beat 3'b001 (nbits 3), then beat 3'b100 (nbits 1, last). The concatenated valid bits 0011 equal {<<3{4'b1001}}.
  - in_dir=0, in_data=4'b1001 -> beat 3'b100, then beat 3'b100 (nbits 1, last).
- WIDTH=32, SLICE=8, in_dir=1, in_data=32'h04030201, out_ready toggled 1,0,0,1,... -> beats 01, 02, 03, 04; each beat held stable while out_ready=0; no beat dropped or duplicated.
- Back-to-back: two words offered continuously with out_ready=1 -> in_ready pulses on the last beat; the second word's first beat follows in the next cycle with no idle cycle.
- rst asserted for one cycle after beat 2 of 4 -> the next cycle shows out_valid=0 and in_ready=1. A new word then starts at beat 0 with correct data.

Source files
------------

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared types and helpers for the streaming pack/unpack family
//               (serializer, slice reverser, future deserializer).
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    // Beat ordering: right stream emits the MSB slice first, left stream
    // reverses the slice order starting from the LSB.
    typedef enum logic {
        STREAM_RIGHT = 1'b0,
        STREAM_LEFT  = 1'b1
    } stream_dir_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } stream_ser_state_e;

    // Number of SLICE-bit beats needed to carry a WIDTH-bit word.
    function automatic int stream_nbeats(input int width, input int slice);
        return (width + slice - 1) / slice;
    endfunction

endpackage : stream_pkg
`default_nettype wire

// File: rtl/stream_slice_reverse.sv
`default_nettype none
// ============================================================================
// Module      : stream_slice_reverse
// Description : Combinational {<< SLICE {i_data}}. Slices are cut from the LSB
//               upward; slice 0 lands at the MSB end and a short remainder
//               slice (the original top bits) lands in the LSBs.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_slice_reverse #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    import stream_pkg::*;

    localparam int NB  = stream_nbeats(WIDTH, SLICE);
    localparam int REM = WIDTH % SLICE;

    // Each input bit i belongs to slice K at offset J; slice K occupies the
    // output field that starts K slices down from the MSB and is WK bits wide.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int K  = i / SLICE;
        localparam int J  = i % SLICE;
        localparam int WK = ((K == NB - 1) && (REM != 0)) ? REM : SLICE;
        assign o_data[WIDTH - K*SLICE - WK + J] = i_data[i];
    end

endmodule : stream_slice_reverse
`default_nettype wire

// File: rtl/stream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : stream_serializer
// Description : Accepts one WIDTH-bit word per handshake and emits it as
//               SLICE-bit beats in right- or left-stream order, with zero
//               bubble between back-to-back words.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_serializer
    import stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_dir,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SLICE-1:0]             out_data,
    output logic [$clog2(SLICE+1)-1:0]   out_nbits,
    output logic                         out_last
);

    localparam int NB  = stream_nbeats(WIDTH, SLICE);
    localparam int REM = WIDTH % SLICE;
    localparam int SW  = NB * SLICE;
    localparam int PAD = SW - WIDTH;
    localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int NBW = $clog2(SLICE + 1);

    localparam logic [CW-1:0]  c_last_beat  = CW'(NB - 1);
    localparam logic [NBW-1:0] c_nbits_full = NBW'(SLICE);
    localparam logic [NBW-1:0] c_nbits_rem  = NBW'(REM);

    stream_ser_state_e r_state;
    stream_ser_state_e w_state_nxt;

    logic [SW-1:0]    r_sreg;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_rev;
    logic [WIDTH-1:0] w_word;
    logic [SW-1:0]    w_load;
    logic             w_last;
    logic             w_load_en;
    logic             w_shift_en;

    stream_slice_reverse #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) u_rev (
        .i_data (in_data),
        .o_data (w_rev)
    );

    // Direction is applied at load time, so in_dir only matters on the
    // accepting cycle; the word is then left-justified with zero padding.
    assign w_word = (stream_dir_e'(in_dir) == STREAM_LEFT) ? w_rev : in_data;
    assign w_load = SW'(w_word) << PAD;
    assign w_last = (r_cnt == c_last_beat);

    assign out_data  = r_sreg[SW-1 -: SLICE];
    assign out_last  = (r_state == S_SEND) && w_last;
    assign out_nbits = (r_state != S_SEND)       ? '0 :
                       (w_last && (REM != 0))    ? c_nbits_rem : c_nbits_full;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake and datapath-control decode.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_load_en   = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load_en   = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (w_last) begin
                        // Last beat leaving: a waiting word is loaded now.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            w_load_en = 1'b1;
                        end else begin
                            w_shift_en  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_shift_en = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shift register and beat counter; the final shift leaves sreg all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (w_load_en) begin
            r_sreg <= w_load;
            r_cnt  <= '0;
        end else if (w_shift_en) begin
            r_sreg <= r_sreg << SLICE;
            r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule : stream_serializer
`default_nettype wire

// File: tb/tb_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_serializer
// Description : Self-checking bench for stream_serializer. Three instances
//               (8/2, 4/3, 32/8) share clk/rst; a per-instance scoreboard
//               built from the streaming-order rules checks every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_serializer;

    localparam int ND = 3;

    typedef struct {
        logic [31:0] data;
        int          nbits;
        bit          last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [ND];
    logic        in_dir    [ND];
    logic        out_ready [ND];
    logic        in_ready  [ND];
    logic        out_valid [ND];
    logic        out_last  [ND];
    logic [31:0] in_data   [ND];
    logic [31:0] out_data  [ND];
    logic [7:0]  out_nbits [ND];

    logic [1:0] od0;  logic [1:0] nb0;
    logic [2:0] od1;  logic [2:0] nb1;
    logic [7:0] od2;  logic [3:0] nb2;

    assign out_data[0]  = {30'd0, od0};
    assign out_data[1]  = {29'd0, od1};
    assign out_data[2]  = {24'd0, od2};
    assign out_nbits[0] = {6'd0, nb0};
    assign out_nbits[1] = {5'd0, nb1};
    assign out_nbits[2] = {4'd0, nb2};

    stream_serializer #(.WIDTH(8), .SLICE(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0][7:0]), .in_dir(in_dir[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(od0), .out_nbits(nb0), .out_last(out_last[0]));

    stream_serializer #(.WIDTH(4), .SLICE(3)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1][3:0]), .in_dir(in_dir[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(od1), .out_nbits(nb1), .out_last(out_last[1]));

    stream_serializer #(.WIDTH(32), .SLICE(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2][31:0]), .in_dir(in_dir[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(od2), .out_nbits(nb2), .out_last(out_last[2]));

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    beat_t       q   [ND][$];
    logic [31:0] cap [ND][$];

    function automatic int cfg_w(input int i);
        case (i)
            0:       return 8;
            1:       return 4;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] wmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Beat k of word d: beats carry min(s, remaining) bits, left-justified.
    // Right stream walks the word from its MSB down; left stream takes the
    // k-th slice counted from the LSB and sends that slice MSB first.
    function automatic beat_t model_beat(input int w, input int s, input logic [31:0] d,
                                         input logic dir, input int k);
        beat_t b;
        int    nb;
        int    src;
        nb      = (w + s - 1) / s;
        b.data  = '0;
        b.last  = (k == nb - 1);
        b.nbits = ((w - k*s) < s) ? (w - k*s) : s;
        for (int t = 0; t < b.nbits; t++) begin
            src = dir ? (k*s + b.nbits - 1 - t) : (w - 1 - k*s - t);
            b.data[s-1-t] = d[src];
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every cycle compares handshake signals and the head beat.
    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            if (rst) begin
                q[i].delete();
            end else begin
                chk($sformatf("d%0d out_valid", i), {31'd0, out_valid[i]},
                    {31'd0, q[i].size() != 0});
                chk($sformatf("d%0d in_ready", i), {31'd0, in_ready[i]},
                    {31'd0, (q[i].size() == 0) || (q[i].size() == 1 && out_ready[i])});
                if (out_valid[i] && q[i].size() != 0) begin
                    chk($sformatf("d%0d out_data", i), out_data[i], q[i][0].data);
                    chk($sformatf("d%0d out_nbits", i), {24'd0, out_nbits[i]}, q[i][0].nbits);
                    chk($sformatf("d%0d out_last", i), {31'd0, out_last[i]}, {31'd0, q[i][0].last});
                end
                if (out_valid[i] && out_ready[i]) begin
                    cap[i].push_back(out_data[i]);
                    if (q[i].size() != 0) void'(q[i].pop_front());
                end
                if (in_valid[i] && in_ready[i]) begin
                    for (int k = 0; k < (cfg_w(i) + cfg_s(i) - 1) / cfg_s(i); k++)
                        q[i].push_back(model_beat(cfg_w(i), cfg_s(i),
                                                  in_data[i] & wmask(cfg_w(i)), in_dir[i], k));
                end
            end
        end
    end

    task automatic send_word(input int i, input logic [31:0] d, input logic dir);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        in_dir[i]   = dir;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (in_ready[i]) ok = 1'b1;
        end
        chk($sformatf("d%0d accept", i), {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_beats(input int i, input int n);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk);
            if (cap[i].size() >= n) ok = 1'b1;
        end
        #1;
        chk($sformatf("d%0d beats seen", i), {31'd0, ok}, 32'd1);
    endtask

    task automatic check_caps(input int i, input string tag, input logic [31:0] e[8], input int n);
        for (int k = 0; k < n; k++)
            chk($sformatf("%s beat%0d", tag, k), (k < cap[i].size()) ? cap[i][k] : 32'hDEAD, e[k]);
    endtask

    initial begin
        logic [31:0] e[8];
        logic        pat[4];
        int          gap;
        bit          ok;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < ND; i++) begin
            in_valid[i] = 1'b0; in_dir[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("d%0d rst out_valid", i), {31'd0, out_valid[i]}, 32'd0);
            chk($sformatf("d%0d rst in_ready", i),  {31'd0, in_ready[i]},  32'd1);
            chk($sformatf("d%0d rst out_data", i),  out_data[i], 32'd0);
            chk($sformatf("d%0d rst out_nbits", i), {24'd0, out_nbits[i]}, 32'd0);
            chk($sformatf("d%0d rst out_last", i),  {31'd0, out_last[i]}, 32'd0);
        end

        // 8/2 right and left stream of 8'hB4
        cap[0].delete(); send_word(0, 32'hB4, 1'b0); wait_beats(0, 4);
        e = '{32'h2, 32'h3, 32'h1, 32'h0, 0, 0, 0, 0}; check_caps(0, "B4 right", e, 4);
        cap[0].delete(); send_word(0, 32'hB4, 1'b1); wait_beats(0, 4);
        e = '{32'h0, 32'h1, 32'h3, 32'h2, 0, 0, 0, 0}; check_caps(0, "B4 left", e, 4);

        // 4/3 remainder beat, both directions
        cap[1].delete(); send_word(1, 32'h9, 1'b1); wait_beats(1, 2);
        e = '{32'h1, 32'h4, 0, 0, 0, 0, 0, 0}; check_caps(1, "1001 left", e, 2);
        cap[1].delete(); send_word(1, 32'h9, 1'b0); wait_beats(1, 2);
        e = '{32'h4, 32'h4, 0, 0, 0, 0, 0, 0}; check_caps(1, "1001 right", e, 2);

        // 32/8 left stream under a 1,0,0,1 backpressure pattern
        out_ready[2] = 1'b0;
        cap[2].delete(); send_word(2, 32'h0403_0201, 1'b1);
        for (int c = 0; c < 60 && cap[2].size() < 4; c++) begin
            @(posedge clk); #1;
            out_ready[2] = pat[c % 4];
        end
        out_ready[2] = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("bp beat count", cap[2].size(), 32'd4);
        e = '{32'h01, 32'h02, 32'h03, 32'h04, 0, 0, 0, 0}; check_caps(2, "bp", e, 4);

        // Back-to-back words on 8/2: second acceptance exactly NB cycles later
        cap[0].delete();
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = 32'h1E; in_dir[0] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin @(negedge clk); if (in_ready[0]) ok = 1'b1; end
        @(posedge clk); #1;
        in_data[0] = 32'hC3; in_dir[0] = 1'b1;
        gap = 0; ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk); gap++;
            if (in_ready[0]) ok = 1'b1;
        end
        @(posedge clk); #1 in_valid[0] = 1'b0;
        chk("b2b accept gap", gap, 32'd4);
        wait_beats(0, 8);
        e = '{32'h0, 32'h1, 32'h3, 32'h2, 32'h3, 32'h0, 32'h0, 32'h3}; check_caps(0, "b2b", e, 8);

        // Reset mid-word after beat 2 of 4, then a fresh word
        cap[0].delete(); send_word(0, 32'h9C, 1'b0); wait_beats(0, 2);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst out_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("midrst in_ready",  {31'd0, in_ready[0]},  32'd1);
        chk("midrst beats", cap[0].size(), 32'd2);
        cap[0].delete(); send_word(0, 32'h5A, 1'b1); wait_beats(0, 4);
        e = '{32'h2, 32'h2, 32'h1, 32'h1, 0, 0, 0, 0}; check_caps(0, "after rst", e, 4);

        // Randomized traffic on all three instances
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < ND; i++) begin
                out_ready[i] = ($urandom_range(0, 3) != 0);
                in_valid[i]  = ($urandom_range(0, 2) != 0);
                in_data[i]   = $urandom() & wmask(cfg_w(i));
                in_dir[i]    = 1'($urandom_range(0, 1));
            end
        end
        for (int i = 0; i < ND; i++) begin in_valid[i] = 1'b0; out_ready[i] = 1'b1; end
        repeat (60) @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++)
            chk($sformatf("d%0d drained", i), q[i].size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stream_serializer
`default_nettype wire
